mac_array_ctrl: RTL and testbench

Job sequencer for the 5-row binary MAC array. It accepts a convolution job: kernel size, operation, active MAC count and ifmap column count. It then drives the array's load_weight, load_ifmaps, ifmaps_input_valid, enable, operation and kernel_size controls, and pops ifmap columns from the show-ahead ifmap FIFO. It also flags when array psum outputs are valid and signals job completion to the top-level control unit.

---
 rtl/mac_array_ctrl_if.sv | 41 ++++
 rtl/mac_array_ctrl.sv | 118 +++++++++++
 tb/tb_mac_array_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_ctrl_if.sv
// Job/array control bundle between the top-level control unit, ifmap FIFO and the MAC array sequencer.
// master drives the job request side; slave is the sequencer.
interface mac_array_ctrl_if #(
  parameter int MAC_NUM = 256
);
  localparam int CNT_W = $clog2(MAC_NUM + 1);

  logic               start;
  logic               abort;
  logic [1:0]         cfg_operation;
  logic [4:0]         cfg_kernel_size;
  logic [CNT_W-1:0]   cfg_mac_count;
  logic [7:0]         cfg_cols;
  logic               weight_ready;
  logic               fifo_valid;
  logic               fifo_rd_en;
  logic               load_weight;
  logic               load_ifmaps;
  logic               ifmaps_input_valid;
  logic [MAC_NUM-1:0] enable;
  logic [1:0]         operation;
  logic [4:0]         kernel_size;
  logic               psum_valid;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output start, abort, cfg_operation, cfg_kernel_size, cfg_mac_count, cfg_cols,
           weight_ready, fifo_valid,
    input  fifo_rd_en, load_weight, load_ifmaps, ifmaps_input_valid, enable,
           operation, kernel_size, psum_valid, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, cfg_operation, cfg_kernel_size, cfg_mac_count, cfg_cols,
           weight_ready, fifo_valid,
    output fifo_rd_en, load_weight, load_ifmaps, ifmaps_input_valid, enable,
           operation, kernel_size, psum_valid, busy, done, cfg_err
  );
endinterface

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the 5-row binary MAC array: weight load, ifmap priming, compute beats,
// psum drain, and completion/abort handling.
module mac_array_ctrl #(
  parameter int MAC_NUM = 256,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  mac_array_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(MAC_NUM + 1);
  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, PRIME, RUN, DRAIN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         col_cnt;
  logic [7:0]         col_lim;
  logic [7:0]         col_inc;
  logic [DRN_W-1:0]   drn_cnt;
  logic [MAC_NUM-1:0] en_mask;
  logic [MAC_NUM-1:0] mask_new;
  logic [MAC_LAT-1:0] psum_vld_p;
  logic               cfg_ok;
  logic               accept;
  logic               kill;
  logic               pop;
  logic               lw_nxt;

  always_comb begin
    cfg_ok = (bus.cfg_kernel_size != 5'd0) && (bus.cfg_kernel_size <= 5'd5) &&
             (bus.cfg_mac_count != '0) && (bus.cfg_mac_count <= CNT_W'(MAC_NUM)) &&
             (bus.cfg_cols >= {3'b000, bus.cfg_kernel_size});
    for (int i = 0; i < MAC_NUM; i++) mask_new[i] = (i < int'(bus.cfg_mac_count));
  end

  assign accept = (state == IDLE) && bus.start && cfg_ok;
  assign kill   = bus.abort && (state != IDLE);

  // FIFO head goes straight to the array, so pop/shift strobes are combinational
  assign bus.load_ifmaps        = (state == PRIME) && bus.fifo_valid;
  assign bus.ifmaps_input_valid = (state == RUN) && bus.fifo_valid;
  assign pop                    = bus.load_ifmaps || bus.ifmaps_input_valid;
  assign bus.fifo_rd_en         = pop;
  assign col_inc                = col_cnt + 8'd1;
  assign bus.psum_valid         = psum_vld_p[MAC_LAT-1];

  // load_weight is registered, so it is scheduled one cycle ahead from the
  // weight_ready seen in the cycle before; LOAD_W exits on the strobe cycle.
  always_comb begin
    state_nxt = state;
    lw_nxt    = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nxt = LOAD_W;
        lw_nxt    = bus.weight_ready;
      end
      LOAD_W: begin
        if (bus.load_weight) state_nxt = (bus.kernel_size > 5'd1) ? PRIME : RUN;
        else                 lw_nxt    = bus.weight_ready;
      end
      PRIME: if (bus.fifo_valid && (col_inc == ({3'b000, bus.kernel_size} - 8'd1)))
        state_nxt = RUN;
      RUN:   if (bus.fifo_valid && (col_inc == col_lim)) state_nxt = DRAIN;
      DRAIN: if (drn_cnt == DRN_LAST) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) begin
      state_nxt = IDLE;
      lw_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      col_cnt         <= '0;
      col_lim         <= '0;
      drn_cnt         <= '0;
      en_mask         <= '0;
      psum_vld_p      <= '0;
      bus.load_weight <= 1'b0;
      bus.enable      <= '0;
      bus.operation   <= '0;
      bus.kernel_size <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.cfg_err     <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.load_weight <= lw_nxt;
      bus.busy        <= (state_nxt != IDLE);
      bus.done        <= (state_nxt == DONE);
      bus.cfg_err     <= (state == IDLE) && bus.start && !cfg_ok;
      bus.enable      <= (state_nxt inside {PRIME, RUN, DRAIN}) ? en_mask : '0;
      drn_cnt         <= ((state == DRAIN) && (state_nxt == DRAIN)) ? drn_cnt + 1'b1 : '0;
      if (accept) begin
        bus.operation   <= bus.cfg_operation;
        bus.kernel_size <= bus.cfg_kernel_size;
        en_mask         <= mask_new;
        col_lim         <= bus.cfg_cols;
        col_cnt         <= '0;
      end else if (pop) begin
        col_cnt <= col_inc;
      end
      // psum valid pipeline: MAC_LAT-deep copy of the compute strobe
      if (kill) begin
        psum_vld_p <= '0;
      end else begin
        for (int i = MAC_LAT - 1; i > 0; i--) psum_vld_p[i] <= psum_vld_p[i-1];
        psum_vld_p[0] <= bus.ifmaps_input_valid;
      end
    end
  end
endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: table of job configs with hand-computed beat counts
// and latencies, plus abort, start-while-busy and reset-mid-job sequences.
module tb_mac_array_ctrl;
  localparam int MAC_NUM = 256;
  localparam int MAC_LAT = 2;

  logic clk = 1'b0;
  logic rst;

  mac_array_ctrl_if #(.MAC_NUM(MAC_NUM)) ifc ();

  mac_array_ctrl #(.MAC_NUM(MAC_NUM), .MAC_LAT(MAC_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k; int cols; int mc; int op;
    bit stall; int wr_hi;
    bit exp_err; int exp_lw; int exp_prime; int exp_comp; int exp_done;
  } vec_t;

  vec_t vecs[10];
  int checks = 0;
  int errors = 0;
  int exp_op = 0;
  int exp_ks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [MAC_NUM-1:0] mk_mask(input int mc);
    logic [MAC_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < mc; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int outs_or();
    return int'(ifc.fifo_rd_en | ifc.load_weight | ifc.load_ifmaps | ifc.ifmaps_input_valid |
                (|ifc.enable) | (|ifc.operation) | (|ifc.kernel_size) | ifc.psum_valid |
                ifc.busy | ifc.done | ifc.cfg_err);
  endfunction

  task automatic set_cfg(input int k, input int cols, input int mc, input int op);
    ifc.cfg_kernel_size = 5'(k);
    ifc.cfg_cols        = 8'(cols);
    ifc.cfg_mac_count   = 9'(mc);
    ifc.cfg_operation   = 2'(op);
  endtask

  task automatic cyc(input bit s, input bit a);
    @(posedge clk);
    #1;
    ifc.start = s;
    ifc.abort = a;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int prime_n = 0, comp_n = 0, psum_n = 0, lw_n = 0, err_n = 0, done_n = 0;
    int lw_ofs = -1, done_ofs = -1, err_ofs = -1, last_psum = -1, viol = 0, n;
    bit iv_d1 = 1'b0, iv_d2 = 1'b0, busy_exp;
    logic [MAC_NUM-1:0] mask;
    mask = mk_mask(v.mc);
    n = v.exp_err ? 4 : v.exp_done + 4;
    set_cfg(v.k, v.cols, v.mc, v.op);
    for (int ofs = 0; ofs < n; ofs++) begin
      @(posedge clk);
      #1;
      ifc.start        = (ofs == 0);
      ifc.abort        = 1'b0;
      ifc.weight_ready = (ofs >= v.wr_hi);
      ifc.fifo_valid   = !(v.stall && ((ofs >= 4 && ofs <= 6) || (ofs >= 12 && ofs <= 15)));
      @(negedge clk);
      busy_exp = !v.exp_err && (ofs >= 1) && (ofs <= v.exp_done);
      if (ifc.busy !== busy_exp) viol++;
      if (ifc.fifo_rd_en !== (ifc.load_ifmaps | ifc.ifmaps_input_valid)) viol++;
      if (ifc.fifo_rd_en && !ifc.fifo_valid) viol++;
      if (ifc.load_ifmaps && ifc.ifmaps_input_valid) viol++;
      if (ifc.psum_valid !== iv_d2) viol++;
      if ((ifc.load_ifmaps || ifc.ifmaps_input_valid) && ifc.enable !== mask) viol++;
      if (!v.exp_err && (ofs == v.exp_done - 1 || ofs == v.exp_done - 2) && ifc.enable !== mask) viol++;
      if ((ifc.done || ifc.load_weight || !ifc.busy) && ifc.enable !== '0) viol++;
      if (ifc.fifo_rd_en && lw_ofs < 0) viol++;
      iv_d2 = iv_d1;
      iv_d1 = ifc.ifmaps_input_valid;
      if (ifc.load_weight) begin lw_n++; if (lw_ofs < 0) lw_ofs = ofs; end
      if (ifc.load_ifmaps) prime_n++;
      if (ifc.ifmaps_input_valid) comp_n++;
      if (ifc.psum_valid) begin psum_n++; last_psum = ofs; end
      if (ifc.done) begin done_n++; if (done_ofs < 0) done_ofs = ofs; end
      if (ifc.cfg_err) begin err_n++; if (err_ofs < 0) err_ofs = ofs; end
    end
    ifc.start = 1'b0;
    chk({tag, "_cfg_err_ofs"}, err_ofs, v.exp_err ? 1 : -1);
    chk({tag, "_cfg_err_cnt"}, err_n, v.exp_err ? 1 : 0);
    chk({tag, "_load_weight_ofs"}, lw_ofs, v.exp_lw);
    chk({tag, "_load_weight_cnt"}, lw_n, v.exp_err ? 0 : 1);
    chk({tag, "_prime_beats"}, prime_n, v.exp_prime);
    chk({tag, "_compute_beats"}, comp_n, v.exp_comp);
    chk({tag, "_psum_beats"}, psum_n, v.exp_comp);
    chk({tag, "_last_psum_ofs"}, last_psum, v.exp_err ? -1 : v.exp_done - 1);
    chk({tag, "_done_ofs"}, done_ofs, v.exp_err ? -1 : v.exp_done);
    chk({tag, "_done_cnt"}, done_n, v.exp_err ? 0 : 1);
    chk({tag, "_protocol_violations"}, viol, 0);
    if (!v.exp_err) begin
      exp_op = v.op;
      exp_ks = v.k;
    end
    chk({tag, "_operation"}, ifc.operation, exp_op);
    chk({tag, "_kernel_size"}, ifc.kernel_size, exp_ks);
  endtask

  initial begin
    //        k  cols  mc  op stall wr_hi err  lw prime comp done
    vecs[0] = '{3,   8,  16, 2, 0,  0,  0,  1,  2,   6,  12};
    vecs[1] = '{1,   1,   1, 1, 0,  0,  0,  1,  0,   1,   5};
    vecs[2] = '{5,  10,   8, 3, 1,  0,  0,  1,  4,   6,  21};
    vecs[3] = '{6,   8,  16, 1, 0,  0,  1, -1,  0,   0,  -1};
    vecs[4] = '{0,   8,  16, 2, 0,  0,  1, -1,  0,   0,  -1};
    vecs[5] = '{3,   2,  16, 0, 0,  0,  1, -1,  0,   0,  -1};
    vecs[6] = '{2,   8,   0, 1, 0,  0,  1, -1,  0,   0,  -1};
    vecs[7] = '{5,   5, 256, 1, 0,  0,  0,  1,  4,   1,   9};
    vecs[8] = '{3,   8,  16, 0, 0, 11,  0, 12,  2,   6,  23};
    vecs[9] = '{2, 255, 256, 2, 0,  0,  0,  1,  1, 254, 259};

    rst = 1'b1;
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.weight_ready = 1'b0; ifc.fifo_valid = 1'b1;
    set_cfg(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_outputs_in_reset", outs_or(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs_after_release", outs_or(), 0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort in RUN, with an ignored start while busy
    ifc.weight_ready = 1'b1;
    ifc.fifo_valid   = 1'b1;
    set_cfg(3, 8, 16, 2);
    cyc(1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b0);
    set_cfg(4, 8, 16, 1);
    cyc(1'b1, 1'b0);
    chk("busy_start_still_busy", ifc.busy, 1);
    cyc(1'b0, 1'b1);
    chk("abort_cycle_in_run", ifc.ifmaps_input_valid, 1);
    chk("abort_cycle_psum", ifc.psum_valid, 1);
    cyc(1'b0, 1'b0);
    chk("abort_busy", ifc.busy, 0);
    chk("abort_enable_zero", ifc.enable == '0, 1);
    chk("abort_psum_valid", ifc.psum_valid, 0);
    chk("abort_done", ifc.done, 0);
    chk("abort_fifo_rd_en", ifc.fifo_rd_en, 0);
    chk("busy_start_kernel_size", ifc.kernel_size, 3);
    chk("busy_start_operation", ifc.operation, 2);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        cyc(1'b0, 1'b0);
        seen += int'(ifc.done | ifc.busy | ifc.psum_valid);
      end
      chk("post_abort_quiet", seen, 0);
    end
    exp_op = 2;
    exp_ks = 3;
    run_vec(vecs[0], "after_abort");

    // asynchronous reset during DRAIN
    set_cfg(1, 1, 4, 3);
    cyc(1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b0);
    chk("drain_busy", ifc.busy, 1);
    chk("drain_psum_valid", ifc.psum_valid, 1);
    chk("drain_enable", ifc.enable == mk_mask(4), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", outs_or(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("after_reset_outputs", outs_or(), 0);
    exp_op = 0;
    exp_ks = 0;
    run_vec(vecs[1], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
